// File: rtl/apb4_master_pkg.sv
// Shared types and constants for the APB4 master engine.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package apb4_master_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // PPROT field bits
    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    // Packed width of one command entry {write, prot, addr, strb, data}.
    // The command/response structs themselves live in the engine because
    // their field widths follow the engine's address/data parameters.
    function automatic int cmd_width(input int addr_size, input int data_size);
        return 1 + 3 + addr_size + data_size / 8 + data_size;
    endfunction

endpackage

// File: rtl/apb4_master_engine_if.sv
// Command, response and APB4 bus bundle for the APB4 master engine.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes; PREADY stalls ACCESS.
interface apb4_master_engine_if #(
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 32
) ();
    // command side
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [PADDR_SIZE-1:0]   cmd_addr;
    logic [PDATA_SIZE/8-1:0] cmd_strb;
    logic [PDATA_SIZE-1:0]   cmd_data;
    logic [2:0]              cmd_prot;
    // response side
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [PDATA_SIZE-1:0]   rsp_data;
    logic                    rsp_write;
    logic                    rsp_err;
    logic                    rsp_timeout;
    logic                    busy;
    // APB4 bus
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [PADDR_SIZE-1:0]   PADDR;
    logic [2:0]              PPROT;
    logic [PDATA_SIZE/8-1:0] PSTRB;
    logic [PDATA_SIZE-1:0]   PWDATA;
    logic [PDATA_SIZE-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_strb, cmd_data, cmd_prot,
        input  rsp_ready, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_data, rsp_write, rsp_err, rsp_timeout, busy,
        output PSEL, PENABLE, PWRITE, PADDR, PPROT, PSTRB, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_strb, cmd_data, cmd_prot,
        output rsp_ready, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_data, rsp_write, rsp_err, rsp_timeout, busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PPROT, PSTRB, PWDATA
    );
endinterface

// File: rtl/apb4_master_fifo.sv
// Generic synchronous first-word-fallthrough FIFO with full/empty/count.
// Latency: a push at edge E is visible on pop_dat from edge E (empty flag drops after E).
// Backpressure: pushes while full and pops while empty are ignored.
module apb4_master_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Head entry is presented directly; forced to zero when empty so it never shows stale data.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/apb4_master_engine.sv
// Queued APB4 master: commands in via FIFO, SETUP/ACCESS sequencing, responses out via FWFT FIFO.
// Latency: command accepted at edge E drives PSEL from E+1; response valid the edge after PREADY.
// Backpressure: cmd_ready = cmd FIFO not full; no new SETUP while rsp FIFO full. Optional APB4_MASTER_TIMEOUT_EN.
module apb4_master_engine
    import apb4_master_pkg::*;
#(
    parameter int PADDR_SIZE     = 16,
    parameter int PDATA_SIZE     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb4_master_engine_if.master bus
);
    localparam int STRB_SIZE = PDATA_SIZE / 8;
    localparam int CAW       = $clog2(CMD_DEPTH);
    localparam int RAW       = $clog2(RSP_DEPTH);
    localparam logic [RAW:0] RSP_LAST = (RAW+1)'(RSP_DEPTH - 1);

    if (PDATA_SIZE % 8 != 0) begin : g_bad_pdata
        $error("PDATA_SIZE must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef struct packed {
        logic                  write;
        logic [2:0]            prot;
        logic [PADDR_SIZE-1:0] addr;
        logic [STRB_SIZE-1:0]  strb;
        logic [PDATA_SIZE-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic [PDATA_SIZE-1:0] data;
        logic                  write;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    state_t               state, state_nxt;
    cmd_t                 cmd_in, cmd_head;
    rsp_t                 rsp_in, rsp_head;
    logic                 cmd_pop, cmd_full, cmd_empty;
    logic                 rsp_push, rsp_pop, rsp_full, rsp_empty, rsp_room;
    logic [CAW:0]         cmd_count;
    logic [RAW:0]         rsp_count;
    logic                 timeout_hit;

    logic                  pwrite_q;
    logic [PADDR_SIZE-1:0] paddr_q;
    logic [2:0]            pprot_q;
    logic [STRB_SIZE-1:0]  pstrb_q;
    logic [PDATA_SIZE-1:0] pwdata_q;

    // Pack the incoming command fields into one FIFO entry
    always_comb begin
        cmd_in       = '0;
        cmd_in.write = bus.cmd_write;
        cmd_in.prot  = bus.cmd_prot;
        cmd_in.addr  = bus.cmd_addr;
        cmd_in.strb  = bus.cmd_strb;
        cmd_in.data  = bus.cmd_data;
    end

    apb4_master_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(PCLK), .rst(PRESET),
        .push(bus.cmd_valid), .push_dat(cmd_in),
        .pop(cmd_pop), .pop_dat(cmd_head),
        .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    apb4_master_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk(PCLK), .rst(PRESET),
        .push(rsp_push), .push_dat(rsp_in),
        .pop(rsp_pop), .pop_dat(rsp_head),
        .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
    );

    assign rsp_pop  = bus.rsp_ready && !rsp_empty;
    // After this cycle's push there is still a free slot for a back-to-back transfer
    assign rsp_room = rsp_pop || (rsp_count < RSP_LAST);

`ifdef APB4_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    // The limit is reached on the TIMEOUT_CYCLES-th wait cycle; PREADY that cycle takes priority
    assign timeout_hit = (state == ACCESS) && !bus.PREADY && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Count ACCESS wait states, restarting at every SETUP
    always_ff @(posedge PCLK) begin
        if (PRESET || state == SETUP)          to_cnt <= '0;
        else if (state == ACCESS && !bus.PREADY) to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, FIFO pop/push and response assembly
    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        rsp_in    = '0;
        case (state)
            IDLE: begin
                if (!cmd_empty && !rsp_full) begin
                    cmd_pop   = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (bus.PREADY || timeout_hit) begin
                    rsp_push       = 1'b1;
                    rsp_in.write   = pwrite_q;
                    rsp_in.data    = (pwrite_q || !bus.PREADY) ? '0 : bus.PRDATA;
                    rsp_in.err     = bus.PREADY ? bus.PSLVERR : 1'b1;
                    rsp_in.timeout = !bus.PREADY;
                    if (!cmd_empty && rsp_room) begin
                        cmd_pop   = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the popped command onto the APB address/data outputs; they hold in IDLE
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pprot_q  <= '0;
            pstrb_q  <= '0;
            pwdata_q <= '0;
        end else if (cmd_pop) begin
            pwrite_q <= cmd_head.write;
            paddr_q  <= cmd_head.addr;
            pprot_q  <= cmd_head.prot;
            pstrb_q  <= cmd_head.write ? cmd_head.strb : '0;
            pwdata_q <= cmd_head.data;
        end
    end

    assign bus.cmd_ready = !cmd_full;
    assign bus.busy      = (state != IDLE) || (cmd_count != '0);
    assign bus.PSEL      = (state != IDLE);
    assign bus.PENABLE   = (state == ACCESS);
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PPROT     = pprot_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.PWDATA    = pwdata_q;

    assign bus.rsp_valid = !rsp_empty;
    assign bus.rsp_data  = rsp_head.data;
    assign bus.rsp_write = rsp_head.write;
    assign bus.rsp_err   = rsp_head.err;
`ifdef APB4_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_head.timeout;
`else
    assign bus.rsp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_apb4_master_engine.sv
// Directed self-checking bench for apb4_master_engine.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: drives PREADY/rsp_ready patterns from directed steps.
module tb_apb4_master_engine;
    import apb4_master_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CD = 4;
    localparam int RD = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          write;
        logic          err;
        logic          timeout;
    } rec_t;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb4_master_engine_if #(.PADDR_SIZE(AW), .PDATA_SIZE(DW)) bus ();

    apb4_master_engine #(
        .PADDR_SIZE(AW), .PDATA_SIZE(DW), .CMD_DEPTH(CD), .RSP_DEPTH(RD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
    );

    // Simple slave: PSLVERR only on completing writes when enabled, PRDATA from a tag or a constant
    logic          pready_v, slv_err_mode, prdata_mode;
    logic [DW-1:0] prdata_v;
    assign bus.PREADY  = pready_v;
    assign bus.PSLVERR = slv_err_mode && bus.PSEL && bus.PENABLE && bus.PWRITE;
    assign bus.PRDATA  = prdata_mode ? {16'hA5A5, bus.PADDR} : prdata_v;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int first_psel = -1;
    int last_psel = 0;
    int psel_cnt = 0;
    rec_t          rsp_q[$];
    logic [AW-1:0] setup_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record what happens at the coming edge, then advance to just after it
    task automatic tick();
        rec_t r;
        if (bus.rsp_valid && bus.rsp_ready) begin
            r.data = bus.rsp_data; r.write = bus.rsp_write;
            r.err = bus.rsp_err;   r.timeout = bus.rsp_timeout;
            rsp_q.push_back(r);
        end
        if (bus.PSEL && !bus.PENABLE) setup_q.push_back(bus.PADDR);
        if (bus.PSEL) begin
            if (first_psel < 0) first_psel = cyc;
            last_psel = cyc;
            psel_cnt++;
        end
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        rsp_q.delete();
        setup_q.delete();
        first_psel = -1;
        last_psel = 0;
        psel_cnt = 0;
    endtask

    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [SW-1:0] s,
                            input logic [DW-1:0] d, input logic [2:0] p);
        int n = 0;
        bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_strb = s;
        bus.cmd_data = d;  bus.cmd_prot = p; bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 50) begin tick(); n++; end
        chk("cmd_accept", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_strb = '0;
        bus.cmd_data = '0; bus.cmd_prot = '0; bus.rsp_ready = 0;
        pready_v = 1; slv_err_mode = 0; prdata_mode = 0; prdata_v = '0;

        // ---- reset ----
        PRESET = 1;
        tick(); tick();
        chk("rst_psel", bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_pwrite", bus.PWRITE, 0);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_pstrb", bus.PSTRB, 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        chk("rst_pprot", bus.PPROT, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        PRESET = 0;
        tick();

        // ---- single write, PREADY=1 ----
        bus.cmd_write = 1; bus.cmd_addr = 16'h0010; bus.cmd_strb = 4'hF;
        bus.cmd_data = 32'hDEADBEEF; bus.cmd_prot = PPROT_PRIV; bus.cmd_valid = 1;
        tick();                              // edge E
        bus.cmd_valid = 0;
        chk("wr_e0_psel", bus.PSEL, 0);
        chk("wr_e0_busy", bus.busy, 1);
        tick();                              // E+1 SETUP
        chk("wr_setup_psel", bus.PSEL, 1);
        chk("wr_setup_penable", bus.PENABLE, 0);
        chk("wr_paddr", bus.PADDR, 16'h0010);
        chk("wr_pwdata", bus.PWDATA, 32'hDEADBEEF);
        chk("wr_pstrb", bus.PSTRB, 4'hF);
        chk("wr_pwrite", bus.PWRITE, 1);
        chk("wr_pprot", bus.PPROT, 3'b001);
        tick();                              // E+2 ACCESS
        chk("wr_access_psel", bus.PSEL, 1);
        chk("wr_access_penable", bus.PENABLE, 1);
        tick();                              // E+3 done
        chk("wr_done_psel", bus.PSEL, 0);
        chk("wr_done_penable", bus.PENABLE, 0);
        chk("wr_rsp_valid", bus.rsp_valid, 1);
        chk("wr_rsp_write", bus.rsp_write, 1);
        chk("wr_rsp_err", bus.rsp_err, 0);
        chk("wr_rsp_data", bus.rsp_data, 0);
        chk("wr_busy_idle", bus.busy, 0);
        chk("wr_paddr_hold", bus.PADDR, 16'h0010);
        bus.rsp_ready = 1; tick(); bus.rsp_ready = 0;
        chk("wr_rsp_popped", bus.rsp_valid, 0);

        // ---- read with 3 wait states ----
        pready_v = 0;
        push_cmd(0, 16'h0020, 4'hF, 32'h11111111, 3'b000);
        tick();                              // SETUP
        chk("rd_setup_psel", bus.PSEL, 1);
        chk("rd_paddr", bus.PADDR, 16'h0020);
        chk("rd_pwrite", bus.PWRITE, 0);
        chk("rd_pstrb_setup", bus.PSTRB, 0);
        tick();                              // ACCESS cycle 1
        for (int i = 0; i < 3; i++) begin
            chk("rd_wait_penable", bus.PENABLE, 1);
            chk("rd_wait_pstrb", bus.PSTRB, 0);
            chk("rd_wait_no_rsp", bus.rsp_valid, 0);
            tick();
        end
        pready_v = 1; prdata_v = 32'h12345678;
        chk("rd_access4_penable", bus.PENABLE, 1);
        tick();
        chk("rd_done_psel", bus.PSEL, 0);
        chk("rd_rsp_valid", bus.rsp_valid, 1);
        chk("rd_rsp_data", bus.rsp_data, 32'h12345678);
        chk("rd_rsp_write", bus.rsp_write, 0);
        chk("rd_rsp_err", bus.rsp_err, 0);
        prdata_v = '0;
        bus.rsp_ready = 1; tick(); bus.rsp_ready = 0;

        // ---- four back-to-back writes ----
        clear_logs();
        bus.rsp_ready = 1;
        for (int i = 0; i < 4; i++) push_cmd(1, AW'(16'h0100 + 4 * i), 4'hF, DW'(i), 3'b000);
        for (int i = 0; i < 40 && rsp_q.size() < 4; i++) tick();
        chk("b2b_rsp_count", rsp_q.size(), 4);
        chk("b2b_psel_cycles", psel_cnt, 8);
        chk("b2b_psel_span", last_psel - first_psel + 1, 8);
        chk("b2b_setup_count", setup_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_order_addr", setup_q[i], 16'h0100 + 4 * i);
            chk("b2b_rsp_write", rsp_q[i].write, 1);
            chk("b2b_rsp_err", rsp_q[i].err, 0);
        end

        // ---- PSLVERR on write, then read ----
        clear_logs();
        slv_err_mode = 1; prdata_v = 32'hCAFEF00D;
        push_cmd(1, 16'h0030, 4'h3, 32'hAAAA5555, 3'b000);
        push_cmd(0, 16'h0034, 4'hF, 32'h0, 3'b000);
        for (int i = 0; i < 40 && rsp_q.size() < 2; i++) tick();
        chk("err_rsp_count", rsp_q.size(), 2);
        chk("err_wr_err", rsp_q[0].err, 1);
        chk("err_wr_write", rsp_q[0].write, 1);
        chk("err_wr_data", rsp_q[0].data, 0);
        chk("err_rd_err", rsp_q[1].err, 0);
        chk("err_rd_data", rsp_q[1].data, 32'hCAFEF00D);
        slv_err_mode = 0; prdata_v = '0;

        // ---- response backpressure ----
        clear_logs();
        bus.rsp_ready = 0; prdata_mode = 1;
        for (int i = 0; i < RD + 2; i++) push_cmd(0, AW'(16'h0040 + 4 * i), 4'h0, DW'(0), 3'b000);
        repeat (12) tick();
        chk("bp_setups", setup_q.size(), RD);
        chk("bp_psel_low", bus.PSEL, 0);
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        chk("bp_cmd_ready_part", bus.cmd_ready, 1);
        chk("bp_busy", bus.busy, 1);
        push_cmd(0, 16'h0058, 4'h0, 32'h0, 3'b000);
        push_cmd(0, 16'h005C, 4'h0, 32'h0, 3'b000);
        chk("bp_cmd_ready_full", bus.cmd_ready, 0);
        repeat (3) tick();
        chk("bp_still_stalled", setup_q.size(), RD);
        bus.rsp_ready = 1;
        for (int i = 0; i < 80 && rsp_q.size() < 8; i++) tick();
        chk("bp_rsp_count", rsp_q.size(), 8);
        chk("bp_setup_total", setup_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("bp_order_addr", setup_q[i], 16'h0040 + 4 * i);
            chk("bp_order_data", rsp_q[i].data, 32'hA5A50040 + 4 * i);
        end
        prdata_mode = 0;

        // ---- reset in the middle of ACCESS ----
        clear_logs();
        pready_v = 0;
        push_cmd(0, 16'h0070, 4'h0, 32'h0, 3'b000);
        push_cmd(1, 16'h0074, 4'hF, 32'h0, 3'b000);
        for (int i = 0; i < 10 && !bus.PENABLE; i++) tick();
        chk("mid_rst_in_access", bus.PENABLE, 1);
        PRESET = 1;
        tick();
        chk("mid_rst_psel", bus.PSEL, 0);
        chk("mid_rst_penable", bus.PENABLE, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        PRESET = 0; pready_v = 1;
        repeat (4) tick();
        chk("post_rst_quiet", psel_cnt - 2, 0);
        chk("post_rst_no_rsp", rsp_q.size(), 0);

`ifdef APB4_MASTER_TIMEOUT_EN
        // ---- timeout with PREADY stuck low ----
        begin
            int acc = 0;
            bus.rsp_ready = 0; pready_v = 0; prdata_v = 32'hFFFF0000;
            push_cmd(0, 16'h0080, 4'h0, 32'h0, 3'b000);
            for (int i = 0; i < 10 && !bus.PENABLE; i++) tick();
            while (bus.PENABLE && acc < 40) begin acc++; tick(); end
            chk("to_access_cycles", acc, TO);
            chk("to_rsp_valid", bus.rsp_valid, 1);
            chk("to_rsp_err", bus.rsp_err, 1);
            chk("to_rsp_timeout", bus.rsp_timeout, 1);
            chk("to_rsp_data", bus.rsp_data, 0);
            pready_v = 1; prdata_v = '0;
            bus.rsp_ready = 1; tick(); bus.rsp_ready = 0;
        end
`else
        // ---- without the timeout feature ACCESS waits indefinitely ----
        bus.rsp_ready = 0; pready_v = 0;
        push_cmd(0, 16'h0080, 4'h0, 32'h0, 3'b000);
        repeat (4 * TO) tick();
        chk("nto_still_access", bus.PENABLE, 1);
        chk("nto_no_rsp", bus.rsp_valid, 0);
        pready_v = 1; prdata_v = 32'h0BADCAFE;
        tick();
        chk("nto_rsp_valid", bus.rsp_valid, 1);
        chk("nto_rsp_timeout", bus.rsp_timeout, 0);
        chk("nto_rsp_data", bus.rsp_data, 32'h0BADCAFE);
        prdata_v = '0;
        bus.rsp_ready = 1; tick(); bus.rsp_ready = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
